// File: rtl/maxpool2_ctrl_pkg.sv
// Shared types, default geometry and size helpers for the layer-2 max-pool
// frame sequencer.
package maxpool2_ctrl_pkg;

  localparam int DEF_WIDTH      = 11;
  localparam int DEF_HEIGHT     = 11;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_OUT_ADDR_W = 5;
  localparam int DEF_CLR_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  function automatic int pix_total(input int w, input int h);
    return w * h;
  endfunction

  // A 2x2 pool drops a trailing odd row/column, hence the integer division.
  function automatic int out_total(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

endpackage

// File: rtl/raster_addr_counter.sv
// Load/enable modulo-N up-counter with a terminal-count flag (count == N-1).
module raster_addr_counter #(
  parameter int W = 7,
  parameter int N = 121
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(N - 1));

  // Load clears to zero and overrides enable; enable wraps at the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/maxpool2_frame_ctrl.sv
// Frame sequencer for the second max-pooling stage: clears the datapath, streams
// one raster frame, collects pooled writes. Define MAXPOOL2_WATCHDOG_EN for the DRAIN watchdog.
module maxpool2_frame_ctrl
  import maxpool2_ctrl_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int OUT_ADDR_W = DEF_OUT_ADDR_W,
  parameter int CLR_CYCLES = DEF_CLR_CYCLES
`ifdef MAXPOOL2_WATCHDOG_EN
  ,
  parameter int DRAIN_MAX  = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  dp_rst_n,
  input  logic                  dp_valid,
  input  logic [15:0]           dp_data,
  output logic                  wr_en,
  output logic [OUT_ADDR_W-1:0] wr_addr,
  output logic [15:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int PIX_N = pix_total(WIDTH, HEIGHT);
  localparam int OUT_N = out_total(WIDTH, HEIGHT);
  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t              state;
  logic [CLR_W-1:0]    clr_cnt;
  logic [OUT_ADDR_W:0] out_count;
  logic                rd_tc;
  logic                out_full;
  logic                cnt_clear;
  logic                accept;

`ifdef MAXPOOL2_WATCHDOG_EN
  localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
  logic [DRAIN_W-1:0] drain_cnt;
  logic               err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Counters sit at zero whenever idle, and an abort zeroes them on the same edge.
  assign cnt_clear = (state == S_IDLE) || abort;
  assign accept    = ((state == S_STREAM) || (state == S_DRAIN)) && dp_valid
                     && !out_full && !abort;

  raster_addr_counter #(.W(ADDR_W), .N(PIX_N)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_clear),
    .en    (state == S_STREAM),
    .count (rd_addr),
    .tc    (rd_tc)
  );

  // One extra count value so a full frame reads as OUT_N and never wraps.
  raster_addr_counter #(.W(OUT_ADDR_W + 1), .N(OUT_N + 1)) u_out_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_clear),
    .en    (accept),
    .count (out_count),
    .tc    (out_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= OUT_ADDR_W'(out_count);
        wr_data <= dp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      clr_cnt  <= '0;
      rd_en    <= 1'b0;
      dp_rst_n <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef MAXPOOL2_WATCHDOG_EN
      drain_cnt <= '0;
      err_q     <= 1'b0;
`endif
    end else if (abort && (state != S_IDLE)) begin
      state    <= S_IDLE;
      rd_en    <= 1'b0;
      dp_rst_n <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state   <= S_CLEAR;
            busy    <= 1'b1;
            clr_cnt <= '0;
`ifdef MAXPOOL2_WATCHDOG_EN
            err_q   <= 1'b0;
`endif
          end
        end
        S_CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state    <= S_STREAM;
            rd_en    <= 1'b1;
            dp_rst_n <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (rd_tc) begin
            state <= S_DRAIN;
            rd_en <= 1'b0;
`ifdef MAXPOOL2_WATCHDOG_EN
            drain_cnt <= '0;
`endif
          end
        end
        S_DRAIN: begin
          if (out_full) begin
            state    <= S_DONE;
            done     <= 1'b1;
            dp_rst_n <= 1'b0;
          end
`ifdef MAXPOOL2_WATCHDOG_EN
          else if (drain_cnt == DRAIN_LAST) begin
            state    <= S_DONE;
            done     <= 1'b1;
            dp_rst_n <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          rd_en    <= 1'b0;
          dp_rst_n <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxpool2_frame_ctrl.sv
// Directed bench for maxpool2_frame_ctrl: datapath model drives dp_valid, a
// scoreboard queue holds the expected writes. Honours MAXPOOL2_WATCHDOG_EN.
module tb_maxpool2_frame_ctrl;

  localparam int WIDTH      = 11;
  localparam int HEIGHT     = 11;
  localparam int PIX_TOTAL  = 121;
  localparam int OUT_TOTAL  = 25;
  localparam int CLR_CYCLES = 2;
`ifdef MAXPOOL2_WATCHDOG_EN
  localparam int DRAIN_MAX    = 64;
  localparam int DRAIN_BUDGET = 400;
`else
  localparam int DRAIN_BUDGET = 150;
`endif

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic        dp_rst_n;
  logic        dp_valid = 1'b0;
  logic [15:0] dp_data = 16'h0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        err;

  int      checks = 0;
  int      errors = 0;
  int      wr_count = 0;
  wr_exp_t sb[$];
  wr_exp_t exp_w;

  maxpool2_frame_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .dp_rst_n (dp_rst_n),
    .dp_valid (dp_valid),
    .dp_data  (dp_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_valid(inout int idx, input bit record);
    wr_exp_t e;
    dp_valid = 1'b1;
    dp_data  = 16'($urandom);
    if (record && idx < OUT_TOTAL) begin
      e.addr = idx;
      e.data = dp_data;
      sb.push_back(e);
    end
    idx++;
  endtask

  // Writes are popped from the scoreboard on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      wr_count++;
      checkOutput("wr_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        checkOutput("wr_addr", 32'(wr_addr), 32'(exp_w.addr));
        checkOutput("wr_data", 32'(wr_data), 32'(exp_w.data));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_dp_rst_n"}, 32'(dp_rst_n), 32'd0);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  // One frame: valids on every 5th read cycle, the rest during DRAIN; optional
  // abort or asynchronous reset when read address stop_at is on the bus.
  task automatic applyStimulus(input int n_valid, input int stop_at, input bit hold_start,
                               input bit use_reset);
    int clr_seen, reads, sent, exp_idx, cyc, exp_writes;
    bit expect_done, exp_err;
    sb.delete();
    wr_count = 0;
    exp_idx  = 0;
    sent     = 0;
`ifdef MAXPOOL2_WATCHDOG_EN
    expect_done = 1'b1;
    exp_err     = (n_valid < OUT_TOTAL);
`else
    expect_done = (n_valid >= OUT_TOTAL);
    exp_err     = 1'b0;
`endif
    exp_writes = (n_valid < OUT_TOTAL) ? n_valid : OUT_TOTAL;

    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_err_clear", 32'(err), 32'd0);

    clr_seen = 0;
    while (busy && !rd_en && clr_seen < 16) begin
      checkOutput("clear_dp_rst_n", 32'(dp_rst_n), 32'd0);
      clr_seen++;
      tick();
    end
    checkOutput("clear_cycles", 32'(clr_seen), 32'(CLR_CYCLES));

    reads = 0;
    while (rd_en && reads < PIX_TOTAL + 4) begin
      checkOutput("rd_addr", 32'(rd_addr), 32'(reads));
      checkOutput("stream_dp_rst_n", 32'(dp_rst_n), 32'd1);
      if (reads == stop_at) begin
        if (use_reset) begin
          dp_valid = 1'b0;
          #2 rst_n = 1'b0;
          #1;
          check_reset_values("async_rst");
          checkOutput("async_rst_state", 32'(dut.state), 32'(maxpool2_ctrl_pkg::S_IDLE));
          rst_n = 1'b1;
          tick();
          checkOutput("post_rst_busy", 32'(busy), 32'd0);
          return;
        end
        abort    = 1'b1;
        dp_valid = 1'b1;
        dp_data  = 16'hA5A5;
        tick();
        abort    = 1'b0;
        dp_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_rd_en", 32'(rd_en), 32'd0);
        checkOutput("abort_dp_rst_n", 32'(dp_rst_n), 32'd0);
        checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        repeat (4) begin
          tick();
          checkOutput("abort_no_done", 32'(done), 32'd0);
        end
        checkOutput("abort_sb_empty", 32'(sb.size()), 32'd0);
        return;
      end
      if ((reads % 5) == 4 && sent < n_valid) begin
        drive_valid(exp_idx, 1'b1);
        sent++;
      end else begin
        dp_valid = 1'b0;
      end
      reads++;
      tick();
    end
    checkOutput("read_count", 32'(reads), 32'(PIX_TOTAL));

    cyc = 0;
    while (!done && cyc < DRAIN_BUDGET) begin
      checkOutput("drain_rd_en", 32'(rd_en), 32'd0);
      checkOutput("drain_dp_rst_n", 32'(dp_rst_n), 32'd1);
      if (sent < n_valid) begin
        drive_valid(exp_idx, 1'b1);
        sent++;
      end else begin
        dp_valid = 1'b0;
      end
      cyc++;
      tick();
    end

    if (!expect_done) begin
      dp_valid = 1'b0;
      checkOutput("stall_no_done", 32'(done), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      checkOutput("stall_err", 32'(err), 32'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("stall_abort_busy", 32'(busy), 32'd0);
      checkOutput("stall_writes", 32'(wr_count), 32'(exp_writes));
      checkOutput("stall_sb_empty", 32'(sb.size()), 32'd0);
      return;
    end

    // A leftover pulse lands in DONE and must be ignored.
    if (sent < n_valid) begin
      drive_valid(exp_idx, 1'b0);
      sent++;
    end else begin
      dp_valid = 1'b0;
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_dp_rst_n", 32'(dp_rst_n), 32'd0);
    checkOutput("done_err", 32'(err), 32'(exp_err));
`ifdef MAXPOOL2_WATCHDOG_EN
    if (n_valid < OUT_TOTAL) checkOutput("watchdog_cycles", 32'(cyc), 32'(DRAIN_MAX));
`endif
    tick();
    dp_valid = 1'b0;
    checkOutput("done_once", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("err_sticky", 32'(err), 32'(exp_err));
    checkOutput("write_count", 32'(wr_count), 32'(exp_writes));
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst_n = 1'b1;
    tick();

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_idle", 32'(busy), 32'd0);
    tick();
    checkOutput("start_abort_idle2", 32'(busy), 32'd0);

    $display("[TB] nominal frame");
    applyStimulus(25, -1, 1'b0, 1'b0);

    $display("[TB] start held through frame");
    applyStimulus(25, -1, 1'b1, 1'b0);
    tick();
    checkOutput("hold_restart_busy", 32'(busy), 32'd1);
    checkOutput("hold_restart_rd_en", 32'(rd_en), 32'd0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("hold_abort_busy", 32'(busy), 32'd0);
    tick();

    $display("[TB] abort at read address 60, then fresh frame");
    applyStimulus(25, 60, 1'b0, 1'b0);
    applyStimulus(25, -1, 1'b0, 1'b0);

    $display("[TB] 27 valids");
    applyStimulus(27, -1, 1'b0, 1'b0);

    $display("[TB] 20 valids (short frame)");
    applyStimulus(20, -1, 1'b0, 1'b0);
    tick();
    applyStimulus(25, -1, 1'b0, 1'b0);

    $display("[TB] reset during stream");
    applyStimulus(25, 60, 1'b0, 1'b1);
    tick();
    checkOutput("post_rst_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool2_frame_ctrl.md
# maxpool2_frame_ctrl

Frame sequencer for the second binary max-pooling stage. It holds the 16-channel pooling datapath in reset between frames and streams one WIDTH×HEIGHT feature map per `start` from the layer-2 activation buffer in raster order. It writes every pooled 16-bit result into the next-layer buffer and reports completion. It sits between the conv-2 output buffer and the pooling datapath, under the top-level layer scheduler.

## Interface
- `WIDTH`, 11, input feature-map columns
- `HEIGHT`, 11, input feature-map rows
- `ADDR_W`, 7, read address width (must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT)
- `OUT_ADDR_W`, 5, write address width (must satisfy 2^OUT_ADDR_W ≥ OUT_TOTAL)
- `CLR_CYCLES`, 2, minimum cycles the datapath reset is held after `start`
- `DRAIN_MAX`, 64, watchdog limit in DRAIN (only with the macro)
- `clk`, in, 1, single clock, rising edge
- `rst_n`, in, 1, asynchronous active-low reset
- `start`, in, 1, frame request, sampled in IDLE only
- `abort`, in, 1, cancel the frame in progress
- `rd_en`, out, 1, activation buffer read strobe (1-cycle read latency)
- `rd_addr`, out, ADDR_W, raster read address
- `dp_rst_n`, out, 1, active-low synchronous reset to the pooling datapath
- `dp_valid`, in, 1, `valid_out_maxpool` from the datapath
- `dp_data`, in, 16, pooled bits of channels 1..16 (bit 0 = channel 1)
- `wr_en`, out, 1, next-layer buffer write strobe
- `wr_addr`, out, OUT_ADDR_W, pooled-pixel index
- `wr_data`, out, 16, registered copy of `dp_data`
- `busy`, out, 1, high in every state except IDLE
- `done`, out, 1, one-cycle frame-complete pulse
- `err`, out, 1, sticky watchdog error

## Operation
- OUT_TOTAL = (WIDTH/2)*(HEIGHT/2), using integer division. The default is 25.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- **IDLE:** `dp_rst_n`=0.
  - `start`=1 → CLEAR. `err` clears and all counters zero.
- **CLEAR:** `dp_rst_n`=0 for CLR_CYCLES cycles, then → STREAM.
- **STREAM:** `rd_en`=1 and `dp_rst_n`=1.
  - `rd_addr` counts 0..WIDTH*HEIGHT−1, one step per cycle, with no gaps.
  - After the last address issues → DRAIN.
- **DRAIN:** `rd_en`=0 and `dp_rst_n`=1.
  - Wait until the output count equals OUT_TOTAL → DONE.
- **DONE:** `done`=1 for one cycle, `dp_rst_n`=0, then → IDLE.
- **Writes:** every cycle in STREAM or DRAIN with `dp_valid`=1 registers `wr_en`=1, `wr_data`=`dp_data`, and `wr_addr`=out_count, then increments out_count.
  - `dp_valid` is ignored in IDLE, CLEAR and DONE.
  - `dp_valid` is also ignored once out_count = OUT_TOTAL; excess pulses cause no write and no wrap.
- `start` while `busy`=1 is ignored.
- `abort` has priority over every transition. From any non-IDLE state → IDLE on the next edge:
  - `rd_en`=0, `wr_en`=0, `dp_rst_n`=0;
  - no `done` pulse, and counters zero.
- `abort` and `start` high together in IDLE: `abort` wins and the FSM stays in IDLE.

## Timing
- All outputs are registered. Reset values:
  - FSM = IDLE;
  - `rd_en`=0, `rd_addr`=0, `dp_rst_n`=0;
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0;
  - `busy`=0, `done`=0, `err`=0.
- `start` sampled at edge T → `busy`=1 and CLEAR from T+1. The first `rd_en` is at T+1+CLR_CYCLES.
- The pixel for `rd_addr` k reaches the datapath one cycle after it issues. `dp_rst_n` is already high on that cycle.
- `wr_*` appear one cycle after the `dp_valid` that produced them.
- `done` is asserted the cycle after the write of index OUT_TOTAL−1. `busy` drops the cycle after `done`.
- Asserting `rst_n` mid-frame discards the frame immediately and asynchronously.

## Configuration
- `MAXPOOL2_WATCHDOG_EN` defined:
  - a DRAIN cycle counter runs;
  - reaching DRAIN_MAX with out_count < OUT_TOTAL forces DONE, sets `err`=1 and still pulses `done`.
- Not defined: no counter is built, `err` is tied 0, and DRAIN waits indefinitely.

## Structure
- Package `maxpool2_ctrl_pkg` holds:
  - the state enum;
  - the OUT_TOTAL and pixel-count constant functions;
  - the default widths.
- Sub-module `raster_addr_counter`: a load/enable modulo-N counter with a terminal-count flag. It is used for both `rd_addr` and out_count.

## Test plan
- Nominal frame with defaults, datapath model emitting 25 valids → 121 consecutive reads at addresses 0..120, 25 writes at `wr_addr` 0..24 with the data matching, one `done`, `err`=0.
- `start` held high through the whole frame → exactly one frame; the next frame begins only after the FSM returns to IDLE.
- `abort` at read address 60 → IDLE next cycle, `dp_rst_n`=0, no `done`. A following `start` re-reads from address 0.
- 27 valids injected → only indices 0..24 are written, and `done` fires once.
- Macro on, model emits 20 valids → `done` and `err`=1 after DRAIN_MAX DRAIN cycles. The next `start` clears `err`.
- `rst_n` low during STREAM → all outputs at their reset values asynchronously, and the FSM is in IDLE.
